// File: rtl/multi_port_fifo.sv
// Circular FIFO with PUSH_PORTS write ports and POP_PORTS read ports; pushed data is visible one cycle later, with no bypass.
// Backpressure: ready_out/valid_out come from registered count only; only contiguous prefixes of push/pop strobes are accepted.
module multi_port_fifo #(
  parameter int PUSH_PORTS = 2,
  parameter int POP_PORTS  = 2,
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush,
  input  logic [PUSH_PORTS-1:0]                 push,
  input  logic [PUSH_PORTS-1:0][DATA_WIDTH-1:0] data_in,
  output logic [PUSH_PORTS-1:0]                 ready_out,
  output logic [POP_PORTS-1:0]                  valid_out,
  output logic [POP_PORTS-1:0][DATA_WIDTH-1:0]  data_out,
  input  logic [POP_PORTS-1:0]                  pop,
  output logic [$clog2(DEPTH):0]                count,
  output logic                                  full,
  output logic                                  empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         free_slots;
  logic [CW-1:0]         n_push;
  logic [CW-1:0]         n_pop;
  logic                  push_run;
  logic                  pop_run;

  assign free_slots = DEPTH_C - count;
  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);

  always_comb begin
    ready_out = '0;
    for (int i = 0; i < PUSH_PORTS; i++) begin
      ready_out[i] = (free_slots > CW'(i));
    end
  end

  always_comb begin
    valid_out = '0;
    data_out  = '0;
    for (int i = 0; i < POP_PORTS; i++) begin
      valid_out[i] = (count > CW'(i));
      data_out[i]  = mem[head + PW'(i)];
    end
  end

  // Only the unbroken run of accepted strobes from lane 0 counts; anything after a gap is dropped.
  always_comb begin
    n_push   = '0;
    push_run = 1'b1;
    for (int i = 0; i < PUSH_PORTS; i++) begin
      if (push_run && push[i] && ready_out[i]) begin
        n_push = n_push + CW'(1);
      end else begin
        push_run = 1'b0;
      end
    end
  end

  always_comb begin
    n_pop   = '0;
    pop_run = 1'b1;
    for (int i = 0; i < POP_PORTS; i++) begin
      if (pop_run && pop[i] && valid_out[i]) begin
        n_pop = n_pop + CW'(1);
      end else begin
        pop_run = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + n_pop[PW-1:0];
      tail  <= tail + n_push[PW-1:0];
      count <= count + n_push - n_pop;
    end
  end

  // Storage is deliberately left unreset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int j = 0; j < PUSH_PORTS; j++) begin
        if (CW'(j) < n_push) begin
          mem[tail + PW'(j)] <= data_in[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_port_fifo.sv
// Directed and short random stimulus for multi_port_fifo with a queue scoreboard of expected contents.
module tb_multi_port_fifo;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic [1:0]        push = '0;
  logic [1:0][31:0]  data_in = '0;
  logic [1:0]        ready_out;
  logic [1:0]        valid_out;
  logic [1:0][31:0]  data_out;
  logic [1:0]        pop = '0;
  logic [3:0]        count;
  logic              full;
  logic              empty;

  int checks = 0;
  int errors = 0;
  logic [31:0] q [$];

  multi_port_fifo #(
    .PUSH_PORTS(2), .POP_PORTS(2), .DEPTH(8), .DATA_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .data_in(data_in),
    .ready_out(ready_out), .valid_out(valid_out), .data_out(data_out),
    .pop(pop), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compares every visible output against the scoreboard queue.
  task automatic check_state(input string tag);
    int sz;
    logic [1:0] exp_rdy, exp_vld;
    sz = q.size();
    for (int i = 0; i < 2; i++) begin
      exp_rdy[i] = ((8 - sz) > i);
      exp_vld[i] = (sz > i);
    end
    chk({tag, ".count"}, 32'(count), 32'(sz));
    chk({tag, ".empty"}, 32'(empty), 32'(sz == 0));
    chk({tag, ".full"}, 32'(full), 32'(sz == 8));
    chk({tag, ".ready"}, 32'(ready_out), 32'(exp_rdy));
    chk({tag, ".valid"}, 32'(valid_out), 32'(exp_vld));
    for (int i = 0; i < 2; i++) begin
      if (i < sz) chk($sformatf("%s.data%0d", tag, i), data_out[i], q[i]);
    end
  endtask

  // Drives one cycle of stimulus, updates the scoreboard, then checks after the edge.
  task automatic step(input string tag, input logic [1:0] p, input logic [31:0] a,
                      input logic [31:0] b, input logic [1:0] po, input logic fl);
    int sz, np, npo;
    logic run;
    push = p; data_in[0] = a; data_in[1] = b; pop = po; flush = fl;
    sz = q.size();
    if (fl) begin
      q.delete();
    end else begin
      npo = 0; run = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (run && po[i] && (sz > i)) npo++; else run = 1'b0;
      end
      np = 0; run = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (run && p[i] && ((8 - sz) > i)) np++; else run = 1'b0;
      end
      repeat (npo) void'(q.pop_front());
      if (np > 0) q.push_back(a);
      if (np > 1) q.push_back(b);
    end
    @(posedge clk);
    #1;
    push = '0; pop = '0; flush = 1'b0;
    check_state(tag);
  endtask

  initial begin
    // 1: reset, then basic push
    #2;
    chk("rst.valid", 32'(valid_out), 32'h0);
    chk("rst.empty", 32'(empty), 32'h1);
    chk("rst.full", 32'(full), 32'h0);
    chk("rst.ready", 32'(ready_out), 32'h3);
    chk("rst.count", 32'(count), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_state("post_rst");
    step("basic", 2'b11, 32'h11, 32'h22, 2'b00, 1'b0);
    chk("basic.valid", 32'(valid_out), 32'h3);
    chk("basic.d0", data_out[0], 32'h11);
    chk("basic.d1", data_out[1], 32'h22);
    chk("basic.count", 32'(count), 32'd2);

    // 2: fill to full
    step("flush0", 2'b00, 0, 0, 2'b00, 1'b1);
    for (int k = 0; k < 4; k++) step("fill", 2'b11, 32'h100 + k * 2, 32'h101 + k * 2, 2'b00, 1'b0);
    chk("full.count", 32'(count), 32'd8);
    chk("full.full", 32'(full), 32'h1);
    chk("full.ready", 32'(ready_out), 32'h0);
    step("full_push", 2'b11, 32'hdead, 32'hbeef, 2'b00, 1'b0);
    chk("full_push.count", 32'(count), 32'd8);
    step("pop1", 2'b00, 0, 0, 2'b01, 1'b0);
    chk("seven.ready", 32'(ready_out), 32'h1);
    step("push_one", 2'b11, 32'h200, 32'h201, 2'b00, 1'b0);
    chk("push_one.count", 32'(count), 32'd8);
    for (int k = 0; k < 4; k++) step("drain", 2'b00, 0, 0, 2'b11, 1'b0);

    // 3: non-contiguous strobes
    step("gap_push", 2'b10, 32'h300, 32'h301, 2'b00, 1'b0);
    chk("gap_push.count", 32'(count), 32'd0);
    step("two", 2'b11, 32'h310, 32'h311, 2'b00, 1'b0);
    step("gap_pop", 2'b00, 0, 0, 2'b10, 1'b0);
    chk("gap_pop.count", 32'(count), 32'd2);

    // 4: wrap-around; steer head to 6 with two entries left
    step("w0", 2'b00, 0, 0, 2'b11, 1'b0);
    step("w1", 2'b11, 32'h400, 32'h401, 2'b00, 1'b0);
    step("w2", 2'b11, 32'h402, 32'h403, 2'b00, 1'b0);
    step("w3", 2'b01, 32'h404, 32'h0, 2'b00, 1'b0);
    step("w4", 2'b00, 0, 0, 2'b11, 1'b0);
    step("w5", 2'b00, 0, 0, 2'b01, 1'b0);
    chk("wrap_pre.head", 32'(dut.head), 32'd6);
    chk("wrap_pre.count", 32'(count), 32'd2);
    step("wrap", 2'b11, 32'h500, 32'h501, 2'b11, 1'b0);
    chk("wrap.head", 32'(dut.head), 32'd0);
    chk("wrap.tail", 32'(dut.tail), 32'd2);
    chk("wrap.count", 32'(count), 32'd2);
    chk("wrap.d0", data_out[0], 32'h500);
    chk("wrap.d1", data_out[1], 32'h501);

    // 5: flush priority
    step("f1", 2'b11, 32'h600, 32'h601, 2'b00, 1'b0);
    step("f2", 2'b01, 32'h602, 32'h0, 2'b00, 1'b0);
    chk("flush_pre.count", 32'(count), 32'd5);
    step("flush", 2'b11, 32'h610, 32'h611, 2'b01, 1'b1);
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.empty", 32'(empty), 32'h1);
    chk("flush.valid", 32'(valid_out), 32'h0);

    // short random traffic exercises repeated wraps
    for (int k = 0; k < 40; k++) begin
      step("rand", 2'($urandom_range(0, 3)), $urandom, $urandom, 2'($urandom_range(0, 3)),
           $urandom_range(0, 15) == 0);
    end

    // 6: asynchronous reset mid-stream
    step("r0", 2'b00, 0, 0, 2'b00, 1'b1);
    for (int k = 0; k < 3; k++) step("r_fill", 2'b11, 32'h700 + k * 2, 32'h701 + k * 2, 2'b00, 1'b0);
    chk("pre_arst.count", 32'(count), 32'd6);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("arst.count", 32'(count), 32'd0);
    chk("arst.valid", 32'(valid_out), 32'h0);
    chk("arst.empty", 32'(empty), 32'h1);
    chk("arst.full", 32'(full), 32'h0);
    chk("arst.ready", 32'(ready_out), 32'h3);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_state("arst_rel");
    step("after", 2'b01, 32'h33, 32'h0, 2'b00, 1'b0);
    chk("after.d0", data_out[0], 32'h33);
    chk("after.valid", 32'(valid_out), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_port_fifo.md
# multi_port_fifo

Circular FIFO with several write ports and several read ports, all usable in the same cycle. It sits directly downstream of the push-compaction stage. That stage packs scattered valid inputs into a contiguous prefix of `push` strobes, and this block stores them in arrival order. It presents the oldest entries as a contiguous prefix of `valid_out` lanes for the consuming issue or dispatch logic. Per-port `ready_out` feeds back into the compaction stage's `ready_in`.

## Interface
- `PUSH_PORTS`, default 2: number of write ports.
- `POP_PORTS`, default 2: number of read ports.
- `DEPTH`, default 8: number of entries.
  - Must be a power of two.
  - Must be ≥ `PUSH_PORTS` and ≥ `POP_PORTS`.
- `DATA_WIDTH`, default 32: entry width.
- `clk` in, 1: the only clock; all state updates on its rising edge.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `flush` in, 1: synchronous clear of all contents.
- `push` in, `PUSH_PORTS`: write strobe per port.
- `data_in` in, `PUSH_PORTS` x `DATA_WIDTH`: write data per port.
- `ready_out` out, `PUSH_PORTS`: port i may write this cycle.
- `valid_out` out, `POP_PORTS`: lane i holds the (i+1)-th oldest entry.
- `data_out` out, `POP_PORTS` x `DATA_WIDTH`: entry data per lane.
- `pop` in, `POP_PORTS`: consume lane i.
- `count` out, `$clog2(DEPTH)+1`: number of occupied entries.
- `full` out, 1: `count == DEPTH`.
- `empty` out, 1: `count == 0`.

## Operation
- **State:**
  - Entry memory, `DEPTH` x `DATA_WIDTH`. It is not reset.
  - `head` and `tail` pointers, `$clog2(DEPTH)` bits each. They wrap modulo `DEPTH` naturally.
  - `count` register.
- **Push side:**
  - `ready_out[i] = (DEPTH - count) > i`, computed from registered `count` only.
  - A pop in the same cycle does not grant extra space.
- **Accepted pushes:**
  - `n_push` is the length of the contiguous run of bits set in `push & ready_out`, starting from bit 0.
  - Any bit set after the first zero is ignored, and its data is dropped.
- **Push write:** port j (j < `n_push`) writes `mem[tail + j]`; then `tail += n_push`.
- **Pop side:**
  - `valid_out[i] = count > i`.
  - `data_out[i] = mem[head + i]`, pointer sum taken modulo `DEPTH`.
  - When `valid_out[i] = 0`, `data_out[i]` is don't-care.
- **Accepted pops:**
  - `n_pop` is the length of the contiguous run of bits set in `pop & valid_out`, starting from bit 0.
  - A pop on an invalid lane, or after a gap, is ignored.
- **Pop advance:** `head += n_pop`.
- **Count update:** `count_next = count + n_push - n_pop`, evaluated in `$clog2(DEPTH)+1` bits with no overflow possible.
- **Flush:**
  - Sets `head = tail = count = 0` at the next edge.
  - Takes priority over any push or pop in the same cycle; those pushes are discarded.
- **No bypass:** data pushed in cycle N is never visible on `data_out` in cycle N.

## Timing
- **Reset values** (asynchronous on `rst_n` low, held until release):
  - `head = tail = count = 0`.
  - `valid_out = 0`, `empty = 1`, `full = 0`.
  - `ready_out` all ones.
- **Push-to-visibility latency:** 1 cycle. An entry accepted at edge N appears on `valid_out`/`data_out` after edge N.
- **Output timing:**
  - `ready_out`, `valid_out`, `count`, `full` and `empty` are functions of registered state only.
  - No combinational path from `push` or `pop` to any output.
  - `data_out` depends on `head` and memory only.
- **Full:** all `ready_out = 0`. A simultaneous pop of k entries re-opens k write ports in the next cycle, not the current one.
- **Empty:** all `valid_out = 0`. A push of k entries raises `valid_out[0..k-1]` in the next cycle.
- **Simultaneous push and pop** in one cycle are both applied. `count` changes by the net amount.
- **Wrap-around:** multi-entry writes and reads straddling index `DEPTH-1` → 0 are handled by modulo pointer arithmetic, with no stall or bubble.
- **Reset mid-operation:** contents are lost. The first cycle after release behaves as empty.

## Test plan
Parameters for all scenarios: `PUSH_PORTS=2`, `POP_PORTS=2`, `DEPTH=8`, `DATA_WIDTH=32`.

1. **Reset, then basic push:**
   - Stimulus: reset; then push=2'b11 with data {B,A}=0x22,0x11.
   - Next cycle: `valid_out=2'b11`, `data_out[0]=0x11`, `data_out[1]=0x22`, `count=2`.
2. **Fill to full:**
   - Stimulus: push 2 entries per cycle for 4 cycles.
   - Response: `count=8`, `full=1`, `ready_out=2'b00`.
   - A further push=2'b11 is ignored and `count` stays 8.
   - Then with `count=7`: `ready_out=2'b01`, and push=2'b11 accepts only port 0.
3. **Non-contiguous strobes:**
   - Stimulus: on an empty FIFO, push=2'b10. Then, with 2 entries present, pop=2'b10.
   - Response: the push writes nothing, `count` stays 0. The pop consumes nothing, `count` stays 2.
4. **Wrap-around with concurrent push/pop:**
   - Setup: `head=6`, `count=2`.
   - Stimulus: push 2 and pop 2 in the same cycle.
   - Response: `head=0`, `tail=2`, `count=2`, `data_out` shows the new entries in order.
5. **Flush priority:**
   - Stimulus: with `count=5`, assert `flush` together with push=2'b11 and pop=2'b01.
   - Next cycle: `count=0`, `empty=1`, `valid_out=0`.
6. **Asynchronous reset mid-stream:**
   - Stimulus: drop `rst_n` between clock edges while `count=6`.
   - Response: outputs go to reset values immediately, without waiting for a clock edge.
   - After release, a push of 0x33 emerges on `data_out[0]` one cycle later.
